cla_8bit: RTL and testbench

Registered 8-bit signed adder/subtractor built on a two-level carry-lookahead network. It computes A+B or A−B in two's complement and reports carry-out and signed overflow. It serves as the datapath arithmetic primitive wherever a single-cycle 8-bit add/sub with flags is needed. Results are captured in output registers on the clock edge.

---
 rtl/cla_8bit.sv | 126 ++++++++++++
 tb/tb_cla_8bit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cla_8bit.sv
// ============================================================================
// Module   : cla_8bit
// Purpose  : Registered 8-bit two's-complement adder/subtractor using a
//            two-level carry-lookahead network, with carry-out and overflow.
//            Define CLA_8BIT_IN_REG_EN to add an input register stage (latency 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Add_ctrl,
  output logic [7:0] SUM,
  output logic       C_out,
  output logic       v,
  output logic       out_valid
);

  // Flat 4-bit lookahead block: returns {GG, GP, c3, c2, c1} for one group.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic ci);
    logic c1, c2, c3, gg, gp;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp = &p;
    return {gg, gp, c3, c2, c1};
  endfunction

  logic [7:0] w_a;
  logic [7:0] w_b;
  logic       w_add;
  logic       w_vld;

`ifdef CLA_8BIT_IN_REG_EN
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_add;
  logic       r_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= 8'h00;
      r_b   <= 8'h00;
      r_add <= 1'b0;
      r_vld <= 1'b0;
    end else begin
      r_a   <= A;
      r_b   <= B;
      r_add <= Add_ctrl;
      r_vld <= in_valid;
    end
  end

  assign w_a   = r_a;
  assign w_b   = r_b;
  assign w_add = r_add;
  assign w_vld = r_vld;
`else
  assign w_a   = A;
  assign w_b   = B;
  assign w_add = Add_ctrl;
  assign w_vld = in_valid;
`endif

  logic [7:0] w_bx;
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic       w_c0;
  logic [4:0] w_grp0;
  logic [4:0] w_grp1;
  logic       w_c4;
  logic       w_c8;
  logic [7:0] w_c;
  logic [7:0] w_sum;
  logic       w_ovf;

  // Subtract is A + ~B + 1: invert B and inject the +1 as carry-in.
  assign w_c0 = ~w_add;
  assign w_bx = w_b ^ {8{~w_add}};
  assign w_g  = w_a & w_bx;
  assign w_p  = w_a ^ w_bx;

  assign w_grp0 = cla4(w_g[3:0], w_p[3:0], w_c0);
  assign w_c4   = w_grp0[4] | (w_grp0[3] & w_c0);
  assign w_grp1 = cla4(w_g[7:4], w_p[7:4], w_c4);
  assign w_c8   = w_grp1[4] | (w_grp1[3] & w_grp0[4]) | (w_grp1[3] & w_grp0[3] & w_c0);

  assign w_c   = {w_grp1[2:0], w_c4, w_grp0[2:0], w_c0};
  assign w_sum = w_p ^ w_c;
  assign w_ovf = w_c8 ^ w_c[7];

  logic [7:0] r_sum;
  logic       r_cout;
  logic       r_v;
  logic       r_out_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum       <= 8'h00;
      r_cout      <= 1'b0;
      r_v         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_vld;
      if (w_vld) begin
        r_sum  <= w_sum;
        r_cout <= w_c8;
        r_v    <= w_ovf;
      end
    end
  end

  assign SUM       = r_sum;
  assign C_out     = r_cout;
  assign v         = r_v;
  assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_cla_8bit.sv
// Scoreboard bench for cla_8bit: driver queues hand-computed results, a
// negedge monitor pops on out_valid and checks values, latency and hold.
`default_nettype none

module tb_cla_8bit;

`ifdef CLA_8BIT_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         issue;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic       Add_ctrl;
  logic [7:0] SUM;
  logic       C_out;
  logic       v;
  logic       out_valid;

  cla_8bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Add_ctrl  (Add_ctrl),
    .SUM       (SUM),
    .C_out     (C_out),
    .v         (v),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int   cyc    = 0;
  logic rst_q  = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];
  exp_t held = '{8'h00, 1'b0, 1'b0, 0};

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: reset zeros, popped results on out_valid, held values otherwise.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (!rst_q) begin
        check("rst_sum", int'(SUM), 0);
        check("rst_cout", int'(C_out), 0);
        check("rst_v", int'(v), 0);
        check("rst_out_valid", int'(out_valid), 0);
        held = '{8'h00, 1'b0, 1'b0, 0};
      end else if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sum", int'(SUM), int'(e.sum));
          check("cout", int'(C_out), int'(e.cout));
          check("ovf", int'(v), int'(e.ovf));
          check("latency", cyc - e.issue + 1, LAT);
          held = e;
        end
      end else begin
        check("hold_sum", int'(SUM), int'(held.sum));
        check("hold_cout", int'(C_out), int'(held.cout));
        check("hold_v", int'(v), int'(held.ovf));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic add,
                      input logic [7:0] es, input logic ec, input logic ev);
    @(negedge clk);
    A        = a;
    B        = b;
    Add_ctrl = add;
    in_valid = 1'b1;
    sb.push_back('{es, ec, ev, cyc + 1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      A        = 8'hA5;
      B        = 8'h5A;
    end
  endtask

  task automatic vectors();
    send(8'd2,   8'd3,   1'b1, 8'h05, 1'b0, 1'b0);
    send(8'd2,   8'd3,   1'b0, 8'hFF, 1'b0, 1'b0);
    send(8'd0,   8'd0,   1'b0, 8'h00, 1'b1, 1'b0);
    send(8'h7F,  8'h7F,  1'b1, 8'hFE, 1'b0, 1'b1);
    send(8'h80,  8'h80,  1'b1, 8'h00, 1'b1, 1'b1);
    send(8'h80,  8'h7F,  1'b1, 8'hFF, 1'b0, 1'b0);
    send(8'h80,  8'h7F,  1'b0, 8'h01, 1'b1, 1'b1);
    send(8'h81,  8'h7F,  1'b0, 8'h02, 1'b1, 1'b1);
    send(8'h7F,  8'h7F,  1'b0, 8'h00, 1'b1, 1'b0);
    send(8'hFF,  8'hFF,  1'b1, 8'hFE, 1'b1, 1'b0);
    send(8'hFF,  8'hFF,  1'b0, 8'h00, 1'b1, 1'b0);
    send(8'hFE,  8'hFD,  1'b1, 8'hFB, 1'b1, 1'b0);
    send(8'hFE,  8'hFD,  1'b0, 8'h01, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    A        = 8'd5;
    B        = 8'd3;
    Add_ctrl = 1'b1;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(2);

    vectors();
    idle(4);

    // Sparse traffic with gaps exercises hold between results.
    send(8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1);
    idle(2);
    send(8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0);
    idle(1);
    send(8'h40, 8'h40, 1'b1, 8'h80, 1'b0, 1'b1);
    idle(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
